// File: rtl/csd_conv_ctrl.sv
// csd_conv_ctrl: sequencing controller for the binary-to-CSD conversion datapath.
// Reads NBITS source bits LSB first, emits canonical signed digits into K memory,
// counts nonzero digits and gates host writes to the source memory while a run is active.
// Optional build macro: CSD_TWOS_COMP_EN (two's-complement input, no TAIL digit).
module csd_conv_ctrl #(
  parameter int unsigned NBITS = 8,
  parameter int unsigned AW    = 4,
  parameter int unsigned CW    = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic          i_host_we,
  output logic          o_src_we,
  output logic          o_host_blocked,
  output logic          o_src_re,
  output logic [AW-1:0] o_src_addr,
  input  logic          i_src_rdata,
  output logic          o_we_k,
  output logic [AW-1:0] o_k_addr,
  output logic [1:0]    o_k_data,
  output logic [CW-1:0] o_nz_cnt,
  output logic          o_busy,
  output logic          o_done
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StPrime,
    StRun,
    StTail,
    StDone
  } state_e;

  state_e        r_state, w_state_d;
  logic          r_start_q;
  logic          r_carry, w_carry_d;
  logic          r_cur, w_cur_d;
  logic [AW-1:0] r_idx, w_idx_d;
  logic [CW-1:0] r_nz_cnt, w_nz_cnt_d;

  logic w_trigger;
  logic w_last;
  logic w_ext;
  logic w_nxt;
  logic w_cnext;
  logic w_dnz;
  logic w_dneg;

  // Digit arithmetic for the current RUN position.
  always_comb begin
    w_trigger = i_start & ~r_start_q;
    w_last    = (32'(r_idx) == NBITS - 1);
`ifdef CSD_TWOS_COMP_EN
    // At the last index cur holds the sign bit, which is the extension bit.
    w_ext     = r_cur;
`else
    w_ext     = 1'b0;
`endif
    w_nxt     = w_last ? w_ext : i_src_rdata;
    w_cnext   = (r_cur & w_nxt) | (r_cur & r_carry) | (w_nxt & r_carry);
    // d = cur + carry - 2c' is nonzero only when cur ^ carry; then c' = nxt, so d = 1 - 2*nxt.
    w_dnz     = r_cur ^ r_carry;
    w_dneg    = w_dnz & w_nxt;
  end

  // Next-state and output decode; all outputs default to their idle values.
  always_comb begin
    w_state_d  = r_state;
    w_carry_d  = r_carry;
    w_cur_d    = r_cur;
    w_idx_d    = r_idx;
    w_nz_cnt_d = r_nz_cnt;
    o_src_re   = 1'b0;
    o_src_addr = '0;
    o_we_k     = 1'b0;
    o_k_addr   = '0;
    o_k_data   = 2'b00;
    o_done     = 1'b0;

    case (r_state)
      StIdle: begin
        if (w_trigger) begin
          w_carry_d  = 1'b0;
          w_idx_d    = '0;
          w_nz_cnt_d = '0;
          w_state_d  = StLoad;
        end
      end
      StLoad: begin
        o_src_re   = 1'b1;
        o_src_addr = '0;
        w_state_d  = StPrime;
      end
      StPrime: begin
        w_cur_d = i_src_rdata;
        if (NBITS > 1) begin
          o_src_re   = 1'b1;
          o_src_addr = AW'(1);
        end
        w_state_d = StRun;
      end
      StRun: begin
        o_we_k    = 1'b1;
        o_k_addr  = r_idx;
        o_k_data  = {w_dneg, w_dnz};
        w_carry_d = w_cnext;
        w_cur_d   = w_nxt;
        w_idx_d   = r_idx + AW'(1);
        if (w_dnz) begin
          w_nz_cnt_d = r_nz_cnt + CW'(1);
        end
        // Prefetch two ahead: the read issued now lands as nxt of the following cycle.
        if (32'(r_idx) + 2 < NBITS) begin
          o_src_re   = 1'b1;
          o_src_addr = r_idx + AW'(2);
        end
        if (w_last) begin
`ifdef CSD_TWOS_COMP_EN
          w_state_d = StDone;
`else
          w_state_d = StTail;
`endif
        end
      end
      StTail: begin
        o_we_k   = 1'b1;
        o_k_addr = AW'(NBITS);
        o_k_data = r_carry ? 2'b01 : 2'b00;
        if (r_carry) begin
          w_nz_cnt_d = r_nz_cnt + CW'(1);
        end
        w_state_d = StDone;
      end
      StDone: begin
        o_done    = 1'b1;
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // Source write-port arbitration: host writes are dropped, not queued, while busy.
  always_comb begin
    o_busy         = (r_state != StIdle);
    o_src_we       = i_host_we & ~o_busy;
    o_host_blocked = i_host_we & o_busy;
    o_nz_cnt       = r_nz_cnt;
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= StIdle;
      r_start_q <= 1'b0;
      r_carry   <= 1'b0;
      r_cur     <= 1'b0;
      r_idx     <= '0;
      r_nz_cnt  <= '0;
    end else begin
      r_state   <= w_state_d;
      r_start_q <= i_start;
      r_carry   <= w_carry_d;
      r_cur     <= w_cur_d;
      r_idx     <= w_idx_d;
      r_nz_cnt  <= w_nz_cnt_d;
    end
  end

endmodule

// File: tb/tb_csd_conv_ctrl.sv
// Self-checking bench for csd_conv_ctrl: models source and K memories, predicts CSD digits
// with an independent NAF computation and compares every K write through a scoreboard queue.
module tb_csd_conv_ctrl;
  localparam int unsigned NBITS = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned CW    = 4;
`ifdef CSD_TWOS_COMP_EN
  localparam int unsigned DoneLat = NBITS + 2;
`else
  localparam int unsigned DoneLat = NBITS + 3;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          host_we = 1'b0;
  logic [AW-1:0] h_addr = '0;
  logic          h_data = 1'b0;
  logic          src_rdata = 1'b0;

  logic          o_src_we, o_host_blocked, o_src_re, o_we_k, o_busy, o_done;
  logic [AW-1:0] o_src_addr, o_k_addr;
  logic [1:0]    o_k_data;
  logic [CW-1:0] o_nz_cnt;

  logic          src_mem [2**AW];
  logic [1:0]    k_mem   [2**AW];

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [1:0]    data;
  } kwr_t;

  kwr_t          exp_q[$];
  kwr_t          mon_e;
  logic [CW-1:0] exp_nz = '0;
  int            n_checks = 0;
  int            n_pass = 0;
  int unsigned   cyc = 0;
  int unsigned   t_load = 0;
  int unsigned   done_lat = 0;
  int unsigned   done_cnt = 0;
  logic          prev_busy = 1'b0;

  csd_conv_ctrl #(.NBITS(NBITS), .AW(AW), .CW(CW)) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_start        (start),
    .i_host_we      (host_we),
    .o_src_we       (o_src_we),
    .o_host_blocked (o_host_blocked),
    .o_src_re       (o_src_re),
    .o_src_addr     (o_src_addr),
    .i_src_rdata    (src_rdata),
    .o_we_k         (o_we_k),
    .o_k_addr       (o_k_addr),
    .o_k_data       (o_k_data),
    .o_nz_cnt       (o_nz_cnt),
    .o_busy         (o_busy),
    .o_done         (o_done)
  );

  always #5 clk = ~clk;

  // Memory models: source write via gated port, registered read; K write port.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (o_src_we) src_mem[h_addr] <= h_data;
    if (o_src_re) src_rdata <= src_mem[o_src_addr];
    if (o_we_k) k_mem[o_k_addr] <= o_k_data;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Monitor: run-start time, done pulses and K writes against the scoreboard.
  always @(negedge clk) begin
    if (o_busy && !prev_busy) t_load = cyc;
    prev_busy = o_busy;
    if (o_done) begin
      done_cnt++;
      done_lat = cyc - t_load;
    end
    if (o_we_k) begin
      if (exp_q.size() == 0) begin
        check_eq("k_extra_write", 32'(o_k_addr), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("k_addr", 32'(o_k_addr), 32'(mon_e.addr));
        check_eq("k_data", 32'(o_k_data), 32'(mon_e.data));
      end
    end
  end

  // Reference: non-adjacent form digits, LSB first.
  task automatic push_expected(input logic [7:0] v);
    int n;
    int d;
    int ndig;
    int nz;
    nz = 0;
`ifdef CSD_TWOS_COMP_EN
    n    = v[7] ? int'(v) - 256 : int'(v);
    ndig = NBITS;
`else
    n    = int'(v);
    ndig = NBITS + 1;
`endif
    for (int i = 0; i < ndig; i++) begin
      d = (n & 1) != 0 ? 2 - (n & 3) : 0;
      n = (n - d) >>> 1;
      if (d != 0) nz++;
      exp_q.push_back('{addr: AW'(i), data: (d == 1) ? 2'b01 : (d == -1) ? 2'b11 : 2'b00});
    end
    exp_nz = CW'(nz);
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic d, input logic exp_pass);
    @(negedge clk);
    h_addr  = a;
    h_data  = d;
    host_we = 1'b1;
    #1;
    check_eq("src_we", 32'(o_src_we), 32'(exp_pass));
    check_eq("host_blocked", 32'(o_host_blocked), 32'(!exp_pass));
    @(posedge clk);
    #1;
    host_we = 1'b0;
  endtask

  task automatic load_src(input logic [7:0] v);
    for (int i = 0; i < int'(NBITS); i++) host_write(AW'(i), v[i], 1'b1);
  endtask

  task automatic start_run(input logic [7:0] v);
    push_expected(v);
    @(negedge clk);
    start = 1'b1;
  endtask

  task automatic wait_done(input logic hold);
    int unsigned d0;
    d0 = done_cnt;
    for (int i = 0; i < 60 && done_cnt == d0; i++) begin
      @(negedge clk);
      #1;
    end
    check_eq("done_seen", done_cnt - d0, 1);
    check_eq("done_latency", done_lat, DoneLat);
    check_eq("nz_cnt", 32'(o_nz_cnt), 32'(exp_nz));
    check_eq("k_writes_left", exp_q.size(), 0);
    if (hold) begin
      repeat (20) @(negedge clk);
      check_eq("no_retrigger", done_cnt - d0, 1);
      check_eq("idle_after_hold", 32'(o_busy), 0);
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic full_run(input logic [7:0] v, input logic hold);
    load_src(v);
    start_run(v);
    wait_done(hold);
  endtask

  initial begin
    logic [7:0] v;
    logic       found;
    int unsigned d0;
    for (int i = 0; i < 2**AW; i++) begin
      k_mem[i]   = 2'b10;
      src_mem[i] = 1'b0;
    end

    // Reset state.
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 32'(o_busy), 0);
    check_eq("rst_nz", 32'(o_nz_cnt), 0);
    check_eq("rst_src_re", 32'(o_src_re), 0);
    check_eq("rst_we_k", 32'(o_we_k), 0);
    check_eq("rst_done", 32'(o_done), 0);
    check_eq("rst_k_addr", 32'(o_k_addr), 0);
    check_eq("rst_k_data", 32'(o_k_data), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 169 with start held high: single run, no retrigger.
    full_run(8'd169, 1'b1);
    full_run(8'hFF, 1'b0);
    check_eq("ff_k0", 32'(k_mem[0]), 32'h3);
`ifdef CSD_TWOS_COMP_EN
    check_eq("ff_k8_unwritten", 32'(k_mem[8]), 32'h2);
`else
    check_eq("ff_k8", 32'(k_mem[8]), 32'h1);
`endif
    full_run(8'h77, 1'b0);
    full_run(8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      v = 8'($urandom_range(0, 255));
      full_run(v, 1'b0);
    end

    // Host write during RUN is dropped; a later idle write passes.
    v = 8'h5A;
    load_src(v);
    start_run(v);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1;
      found = o_we_k;
    end
    check_eq("reach_run", 32'(found), 1);
    host_write('0, ~v[0], 1'b0);
    wait_done(1'b0);
    check_eq("src0_kept", 32'(src_mem[0]), 32'(v[0]));
    host_write('0, v[0], 1'b1);

    // Reset at RUN idx 3, then rerun.
    v = 8'hB3;
    load_src(v);
    start_run(v);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(posedge clk);
      #1;
      found = o_we_k && (o_k_addr == AW'(3));
    end
    check_eq("reach_idx3", 32'(found), 1);
    d0 = done_cnt;
    #1;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_busy", 32'(o_busy), 0);
    check_eq("mid_rst_we_k", 32'(o_we_k), 0);
    check_eq("mid_rst_src_re", 32'(o_src_re), 0);
    check_eq("mid_rst_src_addr", 32'(o_src_addr), 0);
    check_eq("mid_rst_k_addr", 32'(o_k_addr), 0);
    check_eq("mid_rst_nz", 32'(o_nz_cnt), 0);
    exp_q.delete();
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("mid_rst_no_done", done_cnt - d0, 0);
    start_run(v);
    wait_done(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/csd_conv_ctrl.md
Name: csd_conv_ctrl

Overview:
- Sequencing controller for the binary-to-CSD conversion datapath.
- Reads NBITS single-bit binary digits, LSB first, from the source digit memory. Computes canonical signed digits with a running carry and writes them into the K memory.
- Counts nonzero CSD digits and signals completion.
- Arbitrates the source memory write port between the host and the conversion run.

Parameters:
- NBITS, 8: number of binary input digits; source addresses 0..NBITS-1.
- AW, 4: address width of source and K memories; must satisfy 2^AW >= NBITS+1.
- CW, 4: width of nz_cnt; must satisfy 2^CW > NBITS+1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  conversion request; rising edge only.
- host_we  in  1  host write strobe to source memory (weCsd).
- src_we  out  1  gated write enable to source memory.
- host_blocked  out  1  one-cycle pulse: host write dropped.
- src_re  out  1  source memory read enable (reCsd).
- src_addr  out  AW  source read address.
- src_rdata  in  1  source bit (memory word LSB); valid the cycle after src_re.
- we_k  out  1  K memory write enable (weK).
- k_addr  out  AW  K write address.
- k_data  out  2  CSD digit: 00 = 0, 01 = +1, 11 = -1 (10 never driven).
- nz_cnt  out  CW  count of nonzero digits from the last run.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset values: state IDLE; all strobes 0; src_addr, k_addr, k_data, nz_cnt, carry, cur, idx all 0; start_q 0.
- Start detect: start_q registers start. Trigger = start & ~start_q, sampled in IDLE only. A level held high does not retrigger; edges outside IDLE are ignored.
- On trigger: carry <= 0, idx <= 0, nz_cnt <= 0. nz_cnt otherwise holds the previous result until the next trigger.
- IDLE: idle; exits on trigger.
- LOAD (1 cycle): src_re=1, src_addr=0.
- PRIME (1 cycle):
  - cur <= src_rdata (b0).
  - If NBITS>1: src_re=1, src_addr=1.
- RUN (NBITS cycles, idx = 0..NBITS-1):
  - nxt = src_rdata if idx+1 < NBITS, else extension bit (0 unsigned).
  - c' = majority(cur, nxt, carry).
  - d = cur + carry - 2c'.
  - Drive we_k=1, k_addr=idx, k_data=enc(d).
  - Update: carry <= c'; cur <= nxt; nz_cnt += (d != 0); idx++.
  - src_re=1, src_addr=idx+2 while idx+2 < NBITS.
  - After idx = NBITS-1, go to TAIL.
- TAIL (1 cycle):
  - we_k=1, k_addr=NBITS, k_data = carry ? 01 : 00.
  - nz_cnt += carry.
- DONE (1 cycle): done=1, then go to IDLE.
- Latency: first RUN write occurs 2 cycles after leaving IDLE. done is asserted in the (NBITS+3)th cycle after IDLE (unsigned mode).
- Arbitration:
  - src_we = host_we & ~busy.
  - host_blocked = host_we & busy.
  - Blocked writes are dropped, not queued.
- A trigger and host_we in the same IDLE cycle: the write passes (busy still 0); the run starts next cycle.
- Reset mid-run: immediate return to IDLE and all reset values. The partially written K memory is left as is; no done pulse.

Optional Feature:
- Macro: CSD_TWOS_COMP_EN.
- Defined:
  - Input is treated as two's complement; the extension bit is b(NBITS-1) instead of 0.
  - TAIL is skipped: RUN goes directly to DONE, and the final carry is discarded.
  - NBITS digits are written; done arrives in cycle NBITS+2.
- Undefined: unsigned conversion, NBITS+1 digits written.

Test Plan:
- Source bits addr0..7 = 1,0,0,1,0,1,0,1 (169), start held high until done:
  - K[0..8] = +1,0,0,+1,0,+1,0,+1,0; nz_cnt=4.
  - done exactly once, 11 cycles after IDLE exit; no second run while start stays high.
- Source 0xFF (all ones): K[0] = -1 (11), K[1..7] = 0, K[8] = +1; nz_cnt=2.
- Source 0x77 (bits 1,1,1,0,1,1,1,0):
  - K[0] = -1, K[3] = -1, K[7] = +1, all other K entries 0; nz_cnt=3.
- Source all zero: nine writes of 00; nz_cnt=0; done asserted.
- host_we pulsed during RUN: src_we=0, host_blocked=1 for that cycle; source contents unchanged. A following IDLE write passes with src_we=1.
- Reset asserted at RUN idx=3:
  - Outputs return to reset values asynchronously; busy=0; no done pulse.
  - A new start edge reruns from LOAD with correct results.
- With CSD_TWOS_COMP_EN, source 0xFF (-1): K[0] = -1, K[1..7] = 0, no write to K[8]; nz_cnt=1; done at cycle 10.
